// File: rtl/sphere_stream_unpacker.sv
// Rebuilds 64-bit Sphere records from the SPI byte stream (count header + N records, MSB-first).
// Latency: record presented one cycle after its 8th byte; frame_done one cycle after the last handshake.
// Backpressure: byte input cannot stall; a record completing while the previous one is unaccepted raises err.
module sphere_stream_unpacker #(
  parameter int MAX_SPHERES = 16,
  parameter int IDX_B       = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             frame_start,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             sphere_valid,
  input  logic             sphere_ready,
  output logic [63:0]      sphere_data,
  output logic [IDX_B-1:0] sphere_idx,
  output logic             frame_done,
  output logic             err,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_HOLD,
    S_ERROR
  } state_t;

  localparam logic [7:0] MAX_N = 8'(MAX_SPHERES);

  state_t           state;
  state_t           state_nxt;
  // Only bytes 0..6 need storing; byte 7 is appended directly when the record loads.
  logic [55:0]      shreg;
  logic [2:0]       byte_cnt;
  logic [IDX_B-1:0] rec_cnt;
  logic [IDX_B-1:0] last_idx;

  logic             xfer;
  logic             hdr_bad;
  logic             rec_done;
  logic             ovf;
  logic             is_last;
  logic [63:0]      assembled;

  assign xfer      = sphere_valid & sphere_ready;
  assign hdr_bad   = (byte_data == 8'd0) || (byte_data > MAX_N);
  assign rec_done  = (state == S_PAYLOAD) && byte_valid && (byte_cnt == 3'd7);
  // Overflow only when the held record is not leaving on this same edge.
  assign ovf       = rec_done && sphere_valid && !sphere_ready;
  assign is_last   = (rec_cnt == last_idx);
  assign assembled = {shreg, byte_data};
  assign busy      = (state == S_HEADER) || (state == S_PAYLOAD) || (state == S_HOLD);

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; frame_start overrides everything.
  always_comb begin
    state_nxt = state;
    if (frame_start) begin
      state_nxt = S_HEADER;
    end else begin
      case (state)
        S_HEADER: begin
          if (byte_valid) state_nxt = hdr_bad ? S_ERROR : S_PAYLOAD;
        end
        S_PAYLOAD: begin
          if (ovf)                     state_nxt = S_ERROR;
          else if (rec_done && is_last) state_nxt = S_HOLD;
        end
        S_HOLD: begin
          if (xfer) state_nxt = S_IDLE;
        end
        default: state_nxt = state;
      endcase
    end
  end

  // Datapath: byte assembly, output record register, counters and flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shreg        <= '0;
      byte_cnt     <= '0;
      rec_cnt      <= '0;
      last_idx     <= '0;
      sphere_valid <= 1'b0;
      sphere_data  <= '0;
      sphere_idx   <= '0;
      frame_done   <= 1'b0;
      err          <= 1'b0;
    end else if (frame_start) begin
      // Restart: any pending or partial record is discarded.
      shreg        <= '0;
      byte_cnt     <= '0;
      rec_cnt      <= '0;
      sphere_valid <= 1'b0;
      frame_done   <= 1'b0;
      err          <= 1'b0;
    end else begin
      frame_done <= (state == S_HOLD) && xfer;
      if (xfer) sphere_valid <= 1'b0;
      case (state)
        S_HEADER: begin
          if (byte_valid) begin
            if (hdr_bad) err <= 1'b1;
            else         last_idx <= IDX_B'(byte_data - 8'd1);
          end
        end
        S_PAYLOAD: begin
          if (byte_valid) begin
            shreg    <= {shreg[47:0], byte_data};
            byte_cnt <= byte_cnt + 3'd1;
            if (rec_done) begin
              if (ovf) begin
                err <= 1'b1;
              end else begin
                sphere_data  <= assembled;
                sphere_idx   <= rec_cnt;
                sphere_valid <= 1'b1;
                if (!is_last) rec_cnt <= rec_cnt + 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sphere_stream_unpacker.sv
// Self-checking bench for sphere_stream_unpacker: directed corners, header table, random frames vs. record-list model.
// Latency: checks exact one-cycle record presentation and registered frame_done in directed sequences.
// Backpressure: random sphere_ready, forced high on record-completing bytes so random frames never overflow.
module tb_sphere_stream_unpacker;

  localparam int MAX_SPHERES = 16;
  localparam int IDX_B       = 4;

  logic             clk;
  logic             rstn;
  logic             frame_start;
  logic             byte_valid;
  logic [7:0]       byte_data;
  logic             sphere_valid;
  logic             sphere_ready;
  logic [63:0]      sphere_data;
  logic [IDX_B-1:0] sphere_idx;
  logic             frame_done;
  logic             err;
  logic             busy;

  sphere_stream_unpacker #(.MAX_SPHERES(MAX_SPHERES), .IDX_B(IDX_B)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .frame_start  (frame_start),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .sphere_valid (sphere_valid),
    .sphere_ready (sphere_ready),
    .sphere_data  (sphere_data),
    .sphere_idx   (sphere_idx),
    .frame_done   (frame_done),
    .err          (err),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int rdy_pct = 100;
  logic [IDX_B-1:0] got_idx[$];
  logic [63:0]      got_dat[$];

  typedef struct {
    logic [7:0] hdr;
    logic       exp_err;
    logic       exp_busy;
    int         exp_recs;
  } hdr_vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic rnd_rdy();
    return ($urandom_range(99) < rdy_pct);
  endfunction

  task automatic clr();
    got_idx.delete();
    got_dat.delete();
    done_cnt = 0;
  endtask

  // One clock with the given inputs; logs handshakes and checks hold-stability under stall.
  task automatic cyc(input logic fs, input logic bv, input logic [7:0] bd, input logic rdy);
    logic             stall;
    logic [63:0]      pd;
    logic [IDX_B-1:0] pi;
    frame_start  = fs;
    byte_valid   = bv;
    byte_data    = bd;
    sphere_ready = rdy;
    stall = sphere_valid && !rdy && !fs;
    pd = sphere_data;
    pi = sphere_idx;
    if (sphere_valid && rdy && !fs) begin
      got_idx.push_back(sphere_idx);
      got_dat.push_back(sphere_data);
    end
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    byte_valid  = 1'b0;
    if (frame_done) done_cnt++;
    if (stall) begin
      check("stall_valid", sphere_valid, 1);
      check("stall_data", sphere_data, pd);
      check("stall_idx", sphere_idx, pi);
    end
  endtask

  task automatic put_bytes(input logic [63:0] d, input int nb, input logic rdy);
    for (int b = 0; b < nb; b++) cyc(1'b0, 1'b1, d[63-8*b -: 8], rdy);
  endtask

  // Sends one record with random gaps; ready forced high on the completing byte.
  task automatic send_rec(input logic [63:0] d, input int gap_pct);
    for (int b = 0; b < 8; b++) begin
      while ($urandom_range(99) < gap_pct) cyc(1'b0, 1'b0, 8'h00, rnd_rdy());
      cyc(1'b0, 1'b1, d[63-8*b -: 8], (b == 7) ? 1'b1 : rnd_rdy());
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  initial begin
    hdr_vec_t    hv[6];
    logic [63:0] recs[$];
    logic [63:0] r0, r1, r2;
    int          n, wait_cyc, gap;

    hv[0] = '{8'h00, 1'b1, 1'b0, 0};
    hv[1] = '{8'h11, 1'b1, 1'b0, 0};
    hv[2] = '{8'hFF, 1'b1, 1'b0, 0};
    hv[3] = '{8'h10, 1'b0, 1'b1, 1};
    hv[4] = '{8'h01, 1'b0, 1'b0, 1};
    hv[5] = '{8'h07, 1'b0, 1'b1, 1};

    rstn = 1'b0; frame_start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; sphere_ready = 1'b0;
    #12;
    check("rst_valid", sphere_valid, 0);
    check("rst_data", sphere_data, 0);
    check("rst_idx", sphere_idx, 0);
    check("rst_done", frame_done, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    #10 rstn = 1'b1;
    @(posedge clk); #1;

    // Single record, exact timing.
    clr();
    cyc(1'b1, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 1'b1, 8'h01, 1'b1);
    check("t1_busy_payload", busy, 1);
    put_bytes(64'h0100800040010F00, 8, 1'b1);
    check("t1_valid", sphere_valid, 1);
    check("t1_data", sphere_data, 64'h0100800040010F00);
    check("t1_idx", sphere_idx, 0);
    check("t1_done_early", frame_done, 0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    check("t1_done", frame_done, 1);
    check("t1_busy", busy, 0);
    check("t1_valid_drop", sphere_valid, 0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    check("t1_done_pulse", frame_done, 0);
    check("t1_nrec", got_dat.size(), 1);

    // N=3 back-to-back.
    clr();
    r0 = 64'h1111_2222_3333_4444; r1 = 64'hA5A5_5A5A_0F0F_F0F0; r2 = 64'hFEDC_BA98_7654_3210;
    cyc(1'b1, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 1'b1, 8'h03, 1'b1);
    put_bytes(r0, 8, 1'b1); put_bytes(r1, 8, 1'b1); put_bytes(r2, 8, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'h00, 1'b1);
    check("t2_nrec", got_dat.size(), 3);
    if (got_dat.size() == 3) begin
      check("t2_d0", got_dat[0], r0); check("t2_i0", got_idx[0], 0);
      check("t2_d1", got_dat[1], r1); check("t2_i1", got_idx[1], 1);
      check("t2_d2", got_dat[2], r2); check("t2_i2", got_idx[2], 2);
    end
    check("t2_err", err, 0);
    check("t2_done_cnt", done_cnt, 1);

    // Overflow with ready held low.
    clr();
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 8'h02, 1'b0);
    put_bytes(r1, 8, 1'b0);
    check("t3_valid", sphere_valid, 1);
    check("t3_data", sphere_data, r1);
    put_bytes(r2, 7, 1'b0);
    check("t3_err_before", err, 0);
    put_bytes({r2[7:0], 56'h0}, 1, 1'b0);
    check("t3_err", err, 1);
    check("t3_hold_valid", sphere_valid, 1);
    check("t3_hold_data", sphere_data, r1);
    check("t3_hold_idx", sphere_idx, 0);
    check("t3_busy", busy, 0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    check("t3_valid_after", sphere_valid, 0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    check("t3_nrec", got_dat.size(), 1);
    check("t3_done_cnt", done_cnt, 0);
    check("t3_err_sticky", err, 1);

    // Header table.
    for (int v = 0; v < 6; v++) begin
      clr();
      cyc(1'b1, 1'b0, 8'h00, 1'b1);
      cyc(1'b0, 1'b1, hv[v].hdr, 1'b1);
      check($sformatf("hdr%0h_err", hv[v].hdr), err, hv[v].exp_err);
      put_bytes(r0, 8, 1'b1);
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
      check($sformatf("hdr%0h_nrec", hv[v].hdr), got_dat.size(), hv[v].exp_recs);
      check($sformatf("hdr%0h_err_after", hv[v].hdr), err, hv[v].exp_err);
      check($sformatf("hdr%0h_busy", hv[v].hdr), busy, hv[v].exp_busy);
    end

    // Restart in the middle of a record.
    clr();
    cyc(1'b1, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 1'b1, 8'h01, 1'b1);
    put_bytes(r1, 5, 1'b1);
    cyc(1'b1, 1'b1, 8'h77, 1'b1);
    cyc(1'b0, 1'b1, 8'h01, 1'b1);
    put_bytes(r2, 8, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    check("t5_nrec", got_dat.size(), 1);
    if (got_dat.size() == 1) check("t5_data", got_dat[0], r2);
    check("t5_err", err, 0);
    check("t5_done_cnt", done_cnt, 1);

    // Asynchronous reset with a record pending.
    clr();
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 8'h02, 1'b0);
    put_bytes(r0, 8, 1'b0);
    put_bytes(r1, 3, 1'b0);
    check("t6_valid_pre", sphere_valid, 1);
    #2 rstn = 1'b0;
    #1;
    check("t6_valid", sphere_valid, 0);
    check("t6_data", sphere_data, 0);
    check("t6_idx", sphere_idx, 0);
    check("t6_busy", busy, 0);
    check("t6_err", err, 0);
    check("t6_done", frame_done, 0);
    #2 rstn = 1'b1;
    @(posedge clk); #1;
    put_bytes(r2, 8, 1'b1);
    put_bytes(r0, 8, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    check("t6_nrec", got_dat.size(), 0);
    check("t6_busy_after", busy, 0);
    check("t6_valid_after", sphere_valid, 0);

    // Random frames against a record-list model.
    for (int f = 0; f < 15; f++) begin
      clr();
      recs.delete();
      n = $urandom_range(MAX_SPHERES, 1);
      rdy_pct = $urandom_range(100, 30);
      gap = $urandom_range(50, 0);
      for (int k = 0; k < n; k++) recs.push_back({$urandom, $urandom});
      cyc(1'b1, 1'b0, 8'h00, rnd_rdy());
      cyc(1'b0, 1'b1, 8'(n), rnd_rdy());
      for (int k = 0; k < n; k++) send_rec(recs[k], gap);
      wait_cyc = 0;
      while (done_cnt == 0 && wait_cyc < 200) begin
        cyc(1'b0, 1'b0, 8'h00, rnd_rdy());
        wait_cyc++;
      end
      check($sformatf("rnd%0d_done_cnt", f), done_cnt, 1);
      check($sformatf("rnd%0d_nrec", f), got_dat.size(), n);
      if (got_dat.size() == n) begin
        for (int k = 0; k < n; k++) begin
          check($sformatf("rnd%0d_d%0d", f, k), got_dat[k], recs[k]);
          check($sformatf("rnd%0d_i%0d", f, k), got_idx[k], k);
        end
      end
      check($sformatf("rnd%0d_err", f), err, 0);
      check($sformatf("rnd%0d_busy", f), busy, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sphere_stream_unpacker.md
Name: sphere_stream_unpacker

Overview:
Receives the byte stream that the host sends over the SPI receiver and rebuilds packed Sphere records (64 bits each) for the scene RAM / ray-tracing core.
It sits between the SPI byte receiver and the sphere buffer.
Each frame is a count header followed by N records, MSB-first.
The block validates framing, hands records downstream with a valid/ready handshake, and flags framing or overflow errors.

Parameters:
MAX_SPHERES, 16, largest legal sphere count in the header byte (1..255)
IDX_B, 4, width of sphere_idx; must be >= clog2(MAX_SPHERES)

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse at SPI chip-select assertion; starts or restarts a frame
byte_valid  in  1  byte_data holds a new byte this cycle (one-cycle strobe, no backpressure)
byte_data  in  8  received byte
sphere_valid  out  1  sphere_data/sphere_idx hold a complete record
sphere_ready  in  1  downstream accepts the record when high together with sphere_valid
sphere_data  out  64  packed Sphere: x[63:48] s16, y[47:33] s15, z[32:18] s15, r[17:12] s6, c[11:0] colour r/g/b
sphere_idx  out  IDX_B  index of the record within the frame, 0-based
frame_done  out  1  one-cycle pulse when the last record of a frame is accepted
err  out  1  sticky error flag, cleared only by frame_start or reset
busy  out  1  high in HEADER, PAYLOAD and HOLD

Behaviour:
- Reset: all outputs 0, state IDLE, byte counter 0, record counter 0, shift register 0.
- States: IDLE, HEADER, PAYLOAD, HOLD, ERROR.
- frame_start, any state, highest priority:
  - goes to HEADER; clears err, counters and sphere_valid;
  - a record still pending is discarded;
  - a byte_valid in the same cycle is ignored.
- IDLE: byte_valid is ignored.
- HEADER, on byte_valid:
  - N = byte_data;
  - N == 0 or N > MAX_SPHERES: err=1, go to ERROR;
  - otherwise store N, go to PAYLOAD.
- PAYLOAD:
  - each byte_valid shifts left 8 into a 64-bit shift register; byte 0 of a record lands in [63:56];
  - a 3-bit byte counter increments and wraps 7->0.
- 8th byte of a record:
  - next cycle, sphere_data = assembled value, sphere_valid=1, sphere_idx = record count;
  - latency from the 8th byte_valid to sphere_valid is 1 cycle;
  - the shift register is free immediately, so bytes of the next record keep arriving.
- Output handshake:
  - sphere_data/sphere_idx stay stable while sphere_valid=1 and sphere_ready=0;
  - transfer happens on sphere_valid & sphere_ready; sphere_valid drops the next cycle unless a new record loads that same cycle (back-to-back allowed).
- Overflow: 8th byte of a new record completes while the output holds an unaccepted record (and no transfer this cycle) -> err=1, ERROR. The pending record stays valid until accepted.
- Last record (record count == N-1 on load): go to HOLD. HOLD ignores bytes.
  - On transfer: frame_done pulses that same cycle as the transfer edge output (registered, high the cycle after the handshake); go to IDLE.
- Extra bytes after N records (HOLD or IDLE): ignored, no error.
- ERROR: bytes ignored, err held, sphere_valid cleared after any pending transfer; leave only via frame_start.
- frame_start in the middle of a record: the partial record is dropped, and no sphere_valid is produced for it.
- Record count width: IDX_B; N <= MAX_SPHERES guarantees no wrap.

Test Plan:
- Reset then frame_start, bytes 0x01, 01 00 80 00 40 01 0F 00, sphere_ready=1 -> one sphere_valid one cycle after the last byte, sphere_data=0x0100800040010F00, sphere_idx=0, frame_done next cycle, busy=0.
- N=3, 24 bytes at one byte per cycle, sphere_ready=1 -> three records with idx 0,1,2; no err; frame_done once.
- N=2, sphere_ready held 0 through both records -> record 0 stays stable, err=1 when the 8th byte of record 1 arrives; after sphere_ready=1, record 0 transfers, no frame_done.
- Header 0x00 and, separately, header 0x11 with MAX_SPHERES=16 -> err=1, no sphere_valid, subsequent bytes ignored.
- frame_start after 5 payload bytes, then a full valid 1-sphere frame -> no record from the partial bytes; the new record is correct and err=0.
- rstn low mid-record with sphere_valid=1 -> all outputs 0 asynchronously; after release, bytes without frame_start are ignored.
